mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/aurora_pkg.sv | 11 +
 rtl/mem_timeout_ctr.sv | 34 +++
 rtl/mem_access_unit.sv | 137 +++++++++++++
 tb/tb_mem_access_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_pkg.sv
// rtl/aurora_pkg.sv - shared defaults and FSM encoding for the memory access unit
package aurora_pkg;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } mau_state_e;
endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - request-cycle counter flagging when a memory request has waited too long
module mem_timeout_ctr
   import aurora_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);
   logic [7:0] count_q, count_d;

   assign expired_o = (count_q == 8'(TIMEOUT - 1));

   // Holds at the terminal count so a late enable cannot wrap it back to zero.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && !expired_o) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - pipeline memory stage: issues one load/store at a time and produces writebacks
module mem_access_unit
   import aurora_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              valid_i,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   input  logic              mem_to_reg_i,
   input  logic              reg_write_i,
   input  logic [DATA_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [4:0]        rd_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [DATA_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              stall_o,
   output logic              wb_valid_o,
   output logic [4:0]        wb_rd_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic              err_o
);
   mau_state_e        state_q, state_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [4:0]        rd_q, rd_d;
   logic [4:0]        wb_rd_q, wb_rd_d;
   logic              we_q, we_d;
   logic              ld_q, ld_d;
   logic              wb_valid_q, wb_valid_d;
   logic              err_q, err_d;
   logic              in_req;
   logic              accept;
   logic              expired;

   assign in_req = (state_q == ST_REQ);
   assign accept = valid_i & (mem_read_i | mem_write_i) & ~in_req;

   mem_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_ctr (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .clear_i   (accept),
      .enable_i  (in_req & ~mem_ack_i),
      .expired_o (expired)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rd_d       = rd_q;
      we_d       = we_q;
      ld_d       = ld_q;
      wb_valid_d = 1'b0;
      wb_rd_d    = '0;
      wb_data_d  = '0;
      err_d      = 1'b0;
      case (state_q)
         ST_REQ: begin
            // Ack takes priority over the timeout in the terminal cycle.
            if (mem_ack_i) begin
               state_d = ST_RESP;
               if (ld_q) begin
                  wb_valid_d = 1'b1;
                  wb_rd_d    = rd_q;
                  wb_data_d  = mem_rdata_i;
               end
            end else if (expired) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            if (accept) begin
               state_d = ST_REQ;
               addr_d  = addr_i;
               wdata_d = wdata_i;
               rd_d    = rd_i;
               we_d    = mem_write_i;
               // Read+write decodes as a store; a load needs a register destination.
               ld_d    = mem_read_i & ~mem_write_i & (mem_to_reg_i | reg_write_i);
            end else if (valid_i && reg_write_i) begin
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_i;
               wb_data_d  = addr_i;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_q       <= '0;
         we_q       <= 1'b0;
         ld_q       <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rd_q       <= rd_d;
         we_q       <= we_d;
         ld_q       <= ld_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         err_q      <= err_d;
      end
   end

   assign mem_req_o   = in_req;
   assign mem_we_o    = in_req & we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign stall_o     = in_req | accept;
   assign wb_valid_o  = wb_valid_q;
   assign wb_rd_o     = wb_rd_q;
   assign wb_data_o   = wb_data_q;
   assign err_o       = err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed vector bench for mem_access_unit
module tb_mem_access_unit;
   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        valid_i = 1'b0;
   logic        mem_read_i = 1'b0;
   logic        mem_write_i = 1'b0;
   logic        mem_to_reg_i = 1'b0;
   logic        reg_write_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic [4:0]  rd_i = '0;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        stall_o;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic        err_o;

   int n_cmp = 0;
   int n_fail = 0;

   mem_access_unit dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .valid_i      (valid_i),
      .mem_read_i   (mem_read_i),
      .mem_write_i  (mem_write_i),
      .mem_to_reg_i (mem_to_reg_i),
      .reg_write_i  (reg_write_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .rd_i         (rd_i),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_ack_i    (mem_ack_i),
      .mem_rdata_i  (mem_rdata_i),
      .stall_o      (stall_o),
      .wb_valid_o   (wb_valid_o),
      .wb_rd_o      (wb_rd_o),
      .wb_data_o    (wb_data_o),
      .err_o        (err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        mr;
      logic        mw;
      logic        m2r;
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rdi;
      int          ack_after;
      logic [31:0] rdata;
      int          exp_stall;
      int          exp_wb;
      int          exp_wb_cyc;
      logic [31:0] exp_data;
      logic [4:0]  exp_rd;
      logic        exp_we;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      valid_i = 1'b0;
      mem_read_i = 1'b0;
      mem_write_i = 1'b0;
      mem_to_reg_i = 1'b0;
      reg_write_i = 1'b0;
      addr_i = '0;
      wdata_i = '0;
      rd_i = '0;
   endtask

   task automatic drive_op(input logic mr, input logic mw, input logic m2r, input logic rw,
                           input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r);
      valid_i = 1'b1;
      mem_read_i = mr;
      mem_write_i = mw;
      mem_to_reg_i = m2r;
      reg_write_i = rw;
      addr_i = a;
      wdata_i = wd;
      rd_i = r;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".mem_req"}, mem_req_o, 0);
      chk({tag, ".mem_we"}, mem_we_o, 0);
      chk({tag, ".mem_addr"}, mem_addr_o, 0);
      chk({tag, ".mem_wdata"}, mem_wdata_o, 0);
      chk({tag, ".stall"}, stall_o, 0);
      chk({tag, ".wb_valid"}, wb_valid_o, 0);
      chk({tag, ".wb_rd"}, wb_rd_o, 0);
      chk({tag, ".wb_data"}, wb_data_o, 0);
      chk({tag, ".err"}, err_o, 0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int stall_cnt = 0;
      int wb_cnt = 0;
      int wb_cyc = -1;
      int req_cyc = 0;
      int err_cnt = 0;
      logic we_seen = 1'b0;
      logic [31:0] wb_data_seen = '0;
      logic [4:0]  wb_rd_seen = '0;
      logic [31:0] addr_seen = '0;
      logic [31:0] wdata_seen = '0;
      string t = $sformatf("vec%0d", idx);
      next_cycle();
      drive_op(v.mr, v.mw, v.m2r, v.rw, v.addr, v.wdata, v.rdi);
      #1;
      if (stall_o) stall_cnt++;
      for (int c = 0; c < 24; c++) begin
         next_cycle();
         clear_inputs();
         mem_ack_i = 1'b0;
         if (mem_req_o) begin
            req_cyc++;
            if (req_cyc == 1) begin
               addr_seen = mem_addr_o;
               wdata_seen = mem_wdata_o;
            end
            if (mem_we_o) we_seen = 1'b1;
            if (req_cyc == v.ack_after) begin
               mem_ack_i = 1'b1;
               mem_rdata_i = v.rdata;
            end
         end
         #1;
         if (stall_o) stall_cnt++;
         if (err_o) err_cnt++;
         if (wb_valid_o) begin
            wb_cnt++;
            wb_cyc = c;
            wb_data_seen = wb_data_o;
            wb_rd_seen = wb_rd_o;
         end
      end
      mem_ack_i = 1'b0;
      chk({t, ".stall_cycles"}, stall_cnt, v.exp_stall);
      chk({t, ".wb_count"}, wb_cnt, v.exp_wb);
      chk({t, ".wb_cycle"}, wb_cyc, v.exp_wb_cyc);
      chk({t, ".wb_data"}, wb_data_seen, v.exp_data);
      chk({t, ".wb_rd"}, wb_rd_seen, v.exp_rd);
      chk({t, ".we"}, we_seen, v.exp_we);
      chk({t, ".req_cycles"}, req_cyc, v.ack_after);
      chk({t, ".err"}, err_cnt, 0);
      chk({t, ".req_addr"}, addr_seen, (v.mr | v.mw) ? v.addr : 32'h0);
      chk({t, ".req_wdata"}, wdata_seen, (v.mr | v.mw) ? v.wdata : 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int req_cyc;
      int err_cnt;
      int err_first;
      int wb_cnt;

      //          mr mw m2r rw addr          wdata         rd  ack rdata         stl wb cyc data          rd  we
      vecs[0] = '{1, 0, 1, 1, 32'h0000_0100, 32'h0,        5,  3,  32'hDEAD_BEEF, 4,  1, 3,  32'hDEAD_BEEF, 5,  0};
      vecs[1] = '{0, 1, 0, 0, 32'h0000_0200, 32'h1234_5678, 0, 1,  32'h0,        2,  0, -1, 32'h0,        0,  1};
      vecs[2] = '{0, 0, 0, 1, 32'h0000_0055, 32'h0,        3,  0,  32'h0,        0,  1, 0,  32'h0000_0055, 3,  0};
      vecs[3] = '{1, 1, 1, 1, 32'h0000_0300, 32'hA5A5_A5A5, 7, 2,  32'h1111_1111, 3,  0, -1, 32'h0,        0,  1};
      vecs[4] = '{1, 0, 1, 1, 32'h0000_0044, 32'h0,        31, 1,  32'hCAFE_F00D, 2,  1, 1,  32'hCAFE_F00D, 31, 0};
      vecs[5] = '{1, 0, 1, 1, 32'h0000_0800, 32'h0,        12, 16, 32'h1357_9BDF, 17, 1, 16, 32'h1357_9BDF, 12, 0};
      vecs[6] = '{0, 0, 0, 0, 32'h0000_0066, 32'h0,        6,  0,  32'h0,        0,  0, -1, 32'h0,        0,  0};

      next_cycle();
      next_cycle();
      check_all_zero("reset");
      reset_i = 1'b0;

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Timeout: load never acked, then a stray ack while idle.
      req_cyc = 0;
      err_cnt = 0;
      err_first = -1;
      wb_cnt = 0;
      next_cycle();
      drive_op(1, 0, 1, 1, 32'h400, 32'h0, 9);
      #1;
      chk("timeout.accept_stall", stall_o, 1);
      for (int c = 0; c < 40; c++) begin
         next_cycle();
         clear_inputs();
         mem_ack_i = (c == 25);
         mem_rdata_i = 32'hFFFF_0000;
         #1;
         if (mem_req_o) req_cyc++;
         if (wb_valid_o) wb_cnt++;
         if (err_o) begin
            err_cnt++;
            if (err_first < 0) err_first = c;
         end
      end
      mem_ack_i = 1'b0;
      chk("timeout.req_cycles", req_cyc, 16);
      chk("timeout.err_pulses", err_cnt, 1);
      chk("timeout.err_cycle", err_first, 16);
      chk("timeout.wb_count", wb_cnt, 0);

      // Reset during the second REQ cycle abandons the request.
      next_cycle();
      drive_op(1, 0, 1, 1, 32'h500, 32'h0, 4);
      #1;
      next_cycle();
      clear_inputs();
      #1;
      chk("rstmid.req1", mem_req_o, 1);
      next_cycle();
      reset_i = 1'b1;
      #1;
      chk("rstmid.req2", mem_req_o, 1);
      next_cycle();
      reset_i = 1'b0;
      #1;
      check_all_zero("rstmid");
      req_cyc = 0;
      err_cnt = 0;
      wb_cnt = 0;
      for (int c = 0; c < 5; c++) begin
         next_cycle();
         mem_ack_i = 1'b1;
         mem_rdata_i = 32'h0000_0BAD;
         #1;
         if (mem_req_o) req_cyc++;
         if (wb_valid_o) wb_cnt++;
         if (err_o) err_cnt++;
      end
      next_cycle();
      mem_ack_i = 1'b0;
      #1;
      if (wb_valid_o) wb_cnt++;
      chk("rstmid.late_req", req_cyc, 0);
      chk("rstmid.late_wb", wb_cnt, 0);
      chk("rstmid.late_err", err_cnt, 0);

      // Back-to-back loads: second accepted in the first one's RESP cycle.
      next_cycle();
      drive_op(1, 0, 1, 1, 32'h600, 32'h0, 1);
      #1;
      chk("b2b.a_stall", stall_o, 1);
      next_cycle();
      clear_inputs();
      mem_ack_i = 1'b1;
      mem_rdata_i = 32'hAAAA_0001;
      #1;
      chk("b2b.a_req", mem_req_o, 1);
      chk("b2b.a_addr", mem_addr_o, 32'h600);
      next_cycle();
      mem_ack_i = 1'b0;
      drive_op(1, 0, 1, 1, 32'h700, 32'h0, 2);
      #1;
      chk("b2b.a_wb_valid", wb_valid_o, 1);
      chk("b2b.a_wb_data", wb_data_o, 32'hAAAA_0001);
      chk("b2b.a_wb_rd", wb_rd_o, 1);
      chk("b2b.b_stall", stall_o, 1);
      chk("b2b.resp_req", mem_req_o, 0);
      next_cycle();
      clear_inputs();
      mem_ack_i = 1'b1;
      mem_rdata_i = 32'hBBBB_0002;
      #1;
      chk("b2b.b_req", mem_req_o, 1);
      chk("b2b.b_addr", mem_addr_o, 32'h700);
      chk("b2b.b_req_wb", wb_valid_o, 0);
      next_cycle();
      mem_ack_i = 1'b0;
      #1;
      chk("b2b.b_wb_valid", wb_valid_o, 1);
      chk("b2b.b_wb_data", wb_data_o, 32'hBBBB_0002);
      chk("b2b.b_wb_rd", wb_rd_o, 2);
      chk("b2b.b_resp_stall", stall_o, 0);
      next_cycle();
      #1;
      chk("b2b.idle_wb", wb_valid_o, 0);
      chk("b2b.idle_req", mem_req_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
